spc_reg_bank: RTL and testbench

Parametrised successor to the single-cycle computer's special-register file. It holds ZR, R1–R3, SP, LR, PC and CPSR (extendable to NUM_REGS entries) and exposes dedicated write channels plus one user read/write port. New behaviour over the previous generation:
- PC auto-increment with a stall input.
- SP push/pop arithmetic with a memory-address output.
- Masked NZCV flag updates.
- Defined write priority with conflict reporting.
- Optional write-to-read bypass.

---
 rtl/spc_regs_pkg.sv | 28 ++
 rtl/spc_sp_unit.sv | 37 +++
 rtl/spc_reg_bank.sv | 133 +++++++++++++
 tb/tb_spc_reg_bank.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spc_regs_pkg.sv
// Shared definitions for the special-register bank.
// Contents:
//   IDX_*    fixed register indices (ZR, R1-R3, SP, LR, PC, CPSR)
//   SP_*     encoding of the sp_op stack-operation field
//   FLAG_*   NZCV positions inside flags_mask / flags_in; in CPSR a flag
//            at position f lives at bit DATA_W-4+f
package spc_regs_pkg;

    localparam int unsigned IDX_ZR   = 0;
    localparam int unsigned IDX_R1   = 1;
    localparam int unsigned IDX_R2   = 2;
    localparam int unsigned IDX_R3   = 3;
    localparam int unsigned IDX_SP   = 4;
    localparam int unsigned IDX_LR   = 5;
    localparam int unsigned IDX_PC   = 6;
    localparam int unsigned IDX_CPSR = 7;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_PUSH = 2'd1;
    localparam logic [1:0] SP_POP  = 2'd2;
    localparam logic [1:0] SP_LOAD = 2'd3;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/spc_sp_unit.sv
// Stack-pointer arithmetic, purely combinational.
// Ports:
//   sp          current SP
//   sp_op       none / push / pop / load
//   sp_wr_data  value used by a load
//   sp_next     SP value to register at the next edge
//   sp_addr     memory address of this cycle's stack access
// Push pre-decrements (address is the new SP), pop post-increments (address
// is the old SP). All arithmetic wraps modulo 2^DATA_W.
module spc_sp_unit #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] sp,
    input  logic [1:0]        sp_op,
    input  logic [DATA_W-1:0] sp_wr_data,
    output logic [DATA_W-1:0] sp_next,
    output logic [DATA_W-1:0] sp_addr
);
    import spc_regs_pkg::*;

    localparam logic [DATA_W-1:0] BYTES = DATA_W'(DATA_W / 8);

    always_comb begin
        sp_next = sp;
        sp_addr = sp;
        case (sp_op)
            SP_PUSH: begin
                sp_next = sp - BYTES;
                sp_addr = sp - BYTES;
            end
            SP_POP:  sp_next = sp + BYTES;
            SP_LOAD: sp_next = sp_wr_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/spc_reg_bank.sv
// Special-register bank: ZR, R1-R3, SP, LR, PC, CPSR plus optional scratch
// entries up to NUM_REGS.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   pc_wr_en/pc_wr_data/pc_hold  branch load and stall of PC auto-increment
//   sp_op/sp_wr_data           stack push/pop/load
//   lr_wr_en/lr_wr_data        link register load
//   flags_wr_en/mask/in        masked NZCV update of CPSR
//   usr_wr_*/usr_rd_*          general user write and combinational read port
//   pc, sp, lr, cpsr           current register values
//   sp_addr                    address of this cycle's stack access
//   usr_wr_dropped             one-cycle pulse after a discarded user write
// A dedicated channel always beats the user port on the same register; the
// losing user write is dropped and reported on the following cycle.
module spc_reg_bank #(
    parameter int                 DATA_W   = 32,
    parameter int                 NUM_REGS = 8,
    parameter int                 PC_STEP  = 4,
    parameter logic [DATA_W-1:0]  RESET_PC = '0,
    parameter logic [DATA_W-1:0]  RESET_SP = DATA_W'('h1000),
    parameter bit                 BYPASS   = 1'b1,
    localparam int                AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_wr_en,
    input  logic [DATA_W-1:0] pc_wr_data,
    input  logic              pc_hold,
    input  logic [1:0]        sp_op,
    input  logic [DATA_W-1:0] sp_wr_data,
    input  logic              lr_wr_en,
    input  logic [DATA_W-1:0] lr_wr_data,
    input  logic              flags_wr_en,
    input  logic [3:0]        flags_mask,
    input  logic [3:0]        flags_in,
    input  logic              usr_wr_en,
    input  logic [AW-1:0]     usr_wr_addr,
    input  logic [DATA_W-1:0] usr_wr_data,
    input  logic [AW-1:0]     usr_rd_addr,
    output logic [DATA_W-1:0] usr_rd_data,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] sp,
    output logic [DATA_W-1:0] lr,
    output logic [DATA_W-1:0] cpsr,
    output logic [DATA_W-1:0] sp_addr,
    output logic              usr_wr_dropped
);
    import spc_regs_pkg::*;

    localparam logic [AW-1:0] A_ZR   = AW'(IDX_ZR);
    localparam logic [AW-1:0] A_SP   = AW'(IDX_SP);
    localparam logic [AW-1:0] A_LR   = AW'(IDX_LR);
    localparam logic [AW-1:0] A_PC   = AW'(IDX_PC);
    localparam logic [AW-1:0] A_CPSR = AW'(IDX_CPSR);

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [DATA_W-1:0] regs_nxt [NUM_REGS];
    logic [DATA_W-1:0] sp_next;
    logic              flags_active;
    logic              usr_blocked;
    logic              usr_accept;

    // Replace only the masked NZCV bits at the top of CPSR.
    function automatic logic [DATA_W-1:0] merge_flags(
        input logic [DATA_W-1:0] cpsr_q,
        input logic [3:0]        mask,
        input logic [3:0]        flags
    );
        logic [DATA_W-1:0] r;
        r = cpsr_q;
        if (mask[FLAG_N]) r[DATA_W-4+FLAG_N] = flags[FLAG_N];
        if (mask[FLAG_Z]) r[DATA_W-4+FLAG_Z] = flags[FLAG_Z];
        if (mask[FLAG_C]) r[DATA_W-4+FLAG_C] = flags[FLAG_C];
        if (mask[FLAG_V]) r[DATA_W-4+FLAG_V] = flags[FLAG_V];
        return r;
    endfunction

    spc_sp_unit #(.DATA_W(DATA_W)) u_sp (
        .sp         (regs[IDX_SP]),
        .sp_op      (sp_op),
        .sp_wr_data (sp_wr_data),
        .sp_next    (sp_next),
        .sp_addr    (sp_addr)
    );

    // A zero mask is not an update, so it does not block a user write to CPSR.
    assign flags_active = flags_wr_en && (flags_mask != 4'd0);

    // PC auto-increment alone never blocks the user port; only a branch does.
    assign usr_blocked = (usr_wr_addr == A_PC   && pc_wr_en)
                      || (usr_wr_addr == A_SP   && sp_op != SP_NONE)
                      || (usr_wr_addr == A_LR   && lr_wr_en)
                      || (usr_wr_addr == A_CPSR && flags_active);

    assign usr_accept = usr_wr_en && (usr_wr_addr != A_ZR) && !usr_blocked;

    // Later assignments win: increment, then user write, then dedicated channels.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_nxt[i] = regs[i];
        regs_nxt[IDX_PC] = pc_hold ? regs[IDX_PC] : regs[IDX_PC] + DATA_W'(PC_STEP);
        if (usr_accept)         regs_nxt[usr_wr_addr] = usr_wr_data;
        if (pc_wr_en)           regs_nxt[IDX_PC]      = pc_wr_data;
        if (sp_op != SP_NONE)   regs_nxt[IDX_SP]      = sp_next;
        if (lr_wr_en)           regs_nxt[IDX_LR]      = lr_wr_data;
        if (flags_active)       regs_nxt[IDX_CPSR]    = merge_flags(regs[IDX_CPSR], flags_mask, flags_in);
        regs_nxt[IDX_ZR] = '0;
    end

    // Register stage: architectural state and the drop pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            regs[IDX_SP]   <= RESET_SP;
            regs[IDX_PC]   <= RESET_PC;
            usr_wr_dropped <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= regs_nxt[i];
            usr_wr_dropped <= usr_wr_en && !usr_accept;
        end
    end

    always_comb begin
        usr_rd_data = regs[usr_rd_addr];
        if (BYPASS && usr_accept && (usr_wr_addr == usr_rd_addr)) usr_rd_data = usr_wr_data;
        if (usr_rd_addr == A_ZR) usr_rd_data = '0;
    end

    assign pc   = regs[IDX_PC];
    assign sp   = regs[IDX_SP];
    assign lr   = regs[IDX_LR];
    assign cpsr = regs[IDX_CPSR];

endmodule

// File: tb/tb_spc_reg_bank.sv
// Testbench for spc_reg_bank: directed vector table from reset, an
// asynchronous-reset sequence, then randomized traffic against a reference.
module tb_spc_reg_bank;

    typedef logic [31:0] w_t;

    typedef struct {
        w_t pc_we, pc_d, hold, sp_op, sp_d, lr_we, lr_d, fl_we, mask, fin;
        w_t uwe, uwa, uwd, ura;
        w_t e_spaddr, e_rd, e_pc, e_sp, e_lr, e_cpsr, e_drop;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       pc_wr_en;
    w_t         pc_wr_data;
    logic       pc_hold;
    logic [1:0] sp_op;
    w_t         sp_wr_data;
    logic       lr_wr_en;
    w_t         lr_wr_data;
    logic       flags_wr_en;
    logic [3:0] flags_mask;
    logic [3:0] flags_in;
    logic       usr_wr_en;
    logic [2:0] usr_wr_addr;
    w_t         usr_wr_data;
    logic [2:0] usr_rd_addr;
    w_t         usr_rd_data;
    w_t         pc, sp, lr, cpsr, sp_addr;
    logic       usr_wr_dropped;

    int n_cmp = 0;
    int n_bad = 0;

    w_t   m  [8];
    w_t   nx [8];
    logic m_drop;

    vec_t tbl [20];

    spc_reg_bank #(
        .DATA_W(32), .NUM_REGS(8), .PC_STEP(4),
        .RESET_PC(32'h0), .RESET_SP(32'h1000), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data), .pc_hold(pc_hold),
        .sp_op(sp_op), .sp_wr_data(sp_wr_data),
        .lr_wr_en(lr_wr_en), .lr_wr_data(lr_wr_data),
        .flags_wr_en(flags_wr_en), .flags_mask(flags_mask), .flags_in(flags_in),
        .usr_wr_en(usr_wr_en), .usr_wr_addr(usr_wr_addr), .usr_wr_data(usr_wr_data),
        .usr_rd_addr(usr_rd_addr), .usr_rd_data(usr_rd_data),
        .pc(pc), .sp(sp), .lr(lr), .cpsr(cpsr), .sp_addr(sp_addr),
        .usr_wr_dropped(usr_wr_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input w_t act, input w_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        pc_wr_en    = v.pc_we[0];
        pc_wr_data  = v.pc_d;
        pc_hold     = v.hold[0];
        sp_op       = v.sp_op[1:0];
        sp_wr_data  = v.sp_d;
        lr_wr_en    = v.lr_we[0];
        lr_wr_data  = v.lr_d;
        flags_wr_en = v.fl_we[0];
        flags_mask  = v.mask[3:0];
        flags_in    = v.fin[3:0];
        usr_wr_en   = v.uwe[0];
        usr_wr_addr = v.uwa[2:0];
        usr_wr_data = v.uwd;
        usr_rd_addr = v.ura[2:0];
    endtask

    task automatic idle();
        pc_wr_en = 1'b0; pc_wr_data = '0; pc_hold = 1'b0;
        sp_op = 2'd0; sp_wr_data = '0;
        lr_wr_en = 1'b0; lr_wr_data = '0;
        flags_wr_en = 1'b0; flags_mask = 4'd0; flags_in = 4'd0;
        usr_wr_en = 1'b0; usr_wr_addr = 3'd0; usr_wr_data = '0; usr_rd_addr = 3'd0;
    endtask

    // Reference: a user write is lost if it targets ZR or a register whose
    // dedicated channel is active in the same cycle.
    function automatic logic ref_accept();
        logic lost;
        lost = (usr_wr_addr == 3'd0)
            || (usr_wr_addr == 3'd6 && pc_wr_en)
            || (usr_wr_addr == 3'd4 && sp_op != 2'd0)
            || (usr_wr_addr == 3'd5 && lr_wr_en)
            || (usr_wr_addr == 3'd7 && flags_wr_en && flags_mask != 4'd0);
        return usr_wr_en && !lost;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // fields: pc_we pc_d hold sp_op sp_d lr_we lr_d fl_we mask fin uwe uwa uwd ura | spaddr rd pc sp lr cpsr drop
        tbl[0]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,        'h1000,0,'h4,'h1000,0,0,0};
        tbl[1]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,        'h1000,0,'h8,'h1000,0,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,        'h1000,0,'hC,'h1000,0,0,0};
        tbl[3]  = '{0,0,1,0,0,0,0,0,0,0,0,0,0,0,        'h1000,0,'hC,'h1000,0,0,0};
        tbl[4]  = '{0,0,1,1,0,0,0,0,0,0,0,0,0,4,        'hFFC,'h1000,'hC,'hFFC,0,0,0};
        tbl[5]  = '{0,0,1,1,0,0,0,0,0,0,0,0,0,4,        'hFF8,'hFFC,'hC,'hFF8,0,0,0};
        tbl[6]  = '{0,0,1,2,0,0,0,0,0,0,0,0,0,4,        'hFF8,'hFF8,'hC,'hFFC,0,0,0};
        tbl[7]  = '{0,0,1,3,0,0,0,0,0,0,0,0,0,4,        'hFFC,'hFFC,'hC,0,0,0,0};
        tbl[8]  = '{0,0,1,1,0,0,0,0,0,0,0,0,0,4,        'hFFFFFFFC,0,'hC,'hFFFFFFFC,0,0,0};
        tbl[9]  = '{0,0,1,0,0,0,0,0,0,0,1,7,'hA5,7,     'hFFFFFFFC,'hA5,'hC,'hFFFFFFFC,0,'hA5,0};
        tbl[10] = '{0,0,1,0,0,0,0,1,'hA,'hF,0,0,0,7,    'hFFFFFFFC,'hA5,'hC,'hFFFFFFFC,0,'hA00000A5,0};
        tbl[11] = '{1,'h200,1,0,0,0,0,0,0,0,1,6,'h300,6,'hFFFFFFFC,'hC,'h200,'hFFFFFFFC,0,'hA00000A5,1};
        tbl[12] = '{1,'h240,1,0,0,0,0,0,0,0,1,2,'h55,2, 'hFFFFFFFC,'h55,'h240,'hFFFFFFFC,0,'hA00000A5,0};
        tbl[13] = '{0,0,1,0,0,0,0,0,0,0,0,0,0,2,        'hFFFFFFFC,'h55,'h240,'hFFFFFFFC,0,'hA00000A5,0};
        tbl[14] = '{0,0,1,0,0,0,0,0,0,0,1,3,'hDEAD,3,   'hFFFFFFFC,'hDEAD,'h240,'hFFFFFFFC,0,'hA00000A5,0};
        tbl[15] = '{0,0,1,0,0,0,0,0,0,0,1,0,'h1234,0,   'hFFFFFFFC,0,'h240,'hFFFFFFFC,0,'hA00000A5,1};
        tbl[16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,3,        'hFFFFFFFC,'hDEAD,'h244,'hFFFFFFFC,0,'hA00000A5,0};
        tbl[17] = '{0,0,1,0,0,1,'h1111,0,0,0,1,5,'h2222,5,'hFFFFFFFC,0,'h244,'hFFFFFFFC,'h1111,'hA00000A5,1};
        tbl[18] = '{0,0,1,0,0,0,0,1,0,'hF,1,7,'hF,7,    'hFFFFFFFC,'hF,'h244,'hFFFFFFFC,'h1111,'hF,0};
        tbl[19] = '{0,0,1,1,0,0,0,0,0,0,1,4,'h50,4,     'hFFFFFFF8,'hFFFFFFFC,'h244,'hFFFFFFF8,'h1111,'hF,1};

        // Reset state, held over several edges
        reset = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst pc", pc, 32'h0);
        chk("rst sp", sp, 32'h1000);
        chk("rst lr", lr, 32'h0);
        chk("rst cpsr", cpsr, 32'h0);
        chk("rst drop", 32'(usr_wr_dropped), 32'h0);
        chk("rst sp_addr", sp_addr, 32'h1000);
        usr_rd_addr = 3'd3;
        #1;
        chk("rst rd r3", usr_rd_data, 32'h0);

        // Directed table from reset release
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d sp_addr", i), sp_addr, tbl[i].e_spaddr);
            chk($sformatf("vec%0d rd", i), usr_rd_data, tbl[i].e_rd);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("vec%0d sp", i), sp, tbl[i].e_sp);
            chk($sformatf("vec%0d lr", i), lr, tbl[i].e_lr);
            chk($sformatf("vec%0d cpsr", i), cpsr, tbl[i].e_cpsr);
            chk($sformatf("vec%0d drop", i), 32'(usr_wr_dropped), tbl[i].e_drop);
        end

        // Asynchronous reset in the middle of a push/branch sequence
        idle();
        pc_wr_en = 1'b1; pc_wr_data = 32'h80; sp_op = 2'd1;
        usr_wr_en = 1'b1; usr_wr_addr = 3'd6; usr_wr_data = 32'h99;
        @(posedge clk);
        #1;
        chk("mid pc", pc, 32'h80);
        chk("mid sp", sp, 32'hFFFFFFF4);
        chk("mid drop", 32'(usr_wr_dropped), 32'h1);
        usr_wr_en = 1'b0; usr_rd_addr = 3'd2;
        #3;
        reset = 1'b0;
        #1;
        chk("async pc", pc, 32'h0);
        chk("async sp", sp, 32'h1000);
        chk("async lr", lr, 32'h0);
        chk("async cpsr", cpsr, 32'h0);
        chk("async drop", 32'(usr_wr_dropped), 32'h0);
        chk("async sp_addr push", sp_addr, 32'hFFC);
        chk("async rd r2", usr_rd_data, 32'h0);
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("held pc", pc, 32'h0);
        chk("held sp", sp, 32'h1000);

        // Randomized traffic against the reference
        for (int k = 0; k < 8; k++) m[k] = '0;
        m[4] = 32'h1000;
        m_drop = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 400; c++) begin
            logic acc;
            w_t   exp_rd, exp_sa;
            pc_wr_en    = ($urandom_range(0, 5) == 0);
            pc_wr_data  = $urandom;
            pc_hold     = ($urandom_range(0, 3) == 0);
            sp_op       = 2'($urandom_range(0, 3));
            sp_wr_data  = $urandom;
            lr_wr_en    = ($urandom_range(0, 3) == 0);
            lr_wr_data  = $urandom;
            flags_wr_en = ($urandom_range(0, 2) == 0);
            flags_mask  = 4'($urandom);
            flags_in    = 4'($urandom);
            usr_wr_en   = ($urandom_range(0, 1) == 0);
            usr_wr_addr = 3'($urandom);
            usr_wr_data = $urandom;
            usr_rd_addr = ($urandom_range(0, 1) == 0) ? usr_wr_addr : 3'($urandom);

            acc = ref_accept();
            if (usr_rd_addr == 3'd0)                     exp_rd = '0;
            else if (acc && usr_wr_addr == usr_rd_addr)  exp_rd = usr_wr_data;
            else                                         exp_rd = m[usr_rd_addr];
            exp_sa = (sp_op == 2'd1) ? m[4] - 32'd4 : m[4];

            @(negedge clk);
            chk($sformatf("rnd%0d rd", c), usr_rd_data, exp_rd);
            chk($sformatf("rnd%0d sp_addr", c), sp_addr, exp_sa);

            nx = m;
            if (acc) nx[usr_wr_addr] = usr_wr_data;
            if (pc_wr_en)                           nx[6] = pc_wr_data;
            else if (!(acc && usr_wr_addr == 3'd6)) nx[6] = pc_hold ? m[6] : m[6] + 32'd4;
            case (sp_op)
                2'd1:    nx[4] = m[4] - 32'd4;
                2'd2:    nx[4] = m[4] + 32'd4;
                2'd3:    nx[4] = sp_wr_data;
                default: ;
            endcase
            if (lr_wr_en) nx[5] = lr_wr_data;
            if (flags_wr_en)
                for (int b = 0; b < 4; b++)
                    if (flags_mask[b]) nx[7][28 + b] = flags_in[b];
            m = nx;
            m_drop = usr_wr_en && !acc;

            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d pc", c), pc, m[6]);
            chk($sformatf("rnd%0d sp", c), sp, m[4]);
            chk($sformatf("rnd%0d lr", c), lr, m[5]);
            chk($sformatf("rnd%0d cpsr", c), cpsr, m[7]);
            chk($sformatf("rnd%0d drop", c), 32'(usr_wr_dropped), 32'(m_drop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
